// File: rtl/machine_pkg.sv
// Shared types for the Ackermann evaluation machine: FSM states and result status codes.
package machine_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ST_OK         = 2'd0,
        ST_STACK_OVF  = 2'd1,
        ST_N_OVF      = 2'd2,
        ST_STEP_LIMIT = 2'd3
    } status_t;

endpackage

// File: rtl/machine_stack.sv
// Single-port synchronous LIFO holding pending m continuations.
// The top entry is readable combinationally so a pop can consume it in the same cycle.
module machine_stack #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      count;
    logic [AW-1:0]    top_idx;

    assign top_idx = count[AW-1:0] - AW'(1);
    assign top     = mem[top_idx];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

    // Occupancy: clear wins, then at most one of push/pop moves the pointer.
    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (push)
            count <= count + (AW+1)'(1);
        else if (pop)
            count <= count - (AW+1)'(1);
    end

    // Storage write at the current free slot; the caller never pushes while full.
    always_ff @(posedge clk) begin
        if (push)
            mem[count[AW-1:0]] <= push_data;
    end

    a_no_push_pop : assert property (@(posedge clk) disable iff (rst) !(push && pop));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full && !clear));

endmodule

// File: rtl/ackermann_machine.sv
// Iterative Ackermann A(m,n) evaluator: one reduction step per clock against an
// explicit continuation stack, with handshake, abort and overflow/step-limit detection.
module ackermann_machine
    import machine_pkg::*;
#(
    parameter int WIDTH       = 30,
    parameter int STACK_DEPTH = 256,
    parameter int STEP_W      = 32,
    parameter int MAX_STEPS   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [WIDTH-1:0]  start_m,
    input  logic [WIDTH-1:0]  start_n,
    input  logic              abort,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_value,
    output logic [1:0]        res_status,
    output logic [STEP_W-1:0] res_steps,
    output logic              busy
);

    state_t            state, state_nxt;
    status_t           status, fail_code;
    logic [WIDTH-1:0]  cur_m, n, m_dec;
    logic [STEP_W-1:0] steps, steps_inc;

    logic m_zero, n_zero, step_push, step_pop;
    logic err_stack, err_n, err_limit, fail, run_done;
    logic start_acc, abort_act;
    logic stk_push, stk_pop, stk_clear, stk_full, stk_empty;
    logic [WIDTH-1:0] stk_top;

    assign start_acc = start_valid && (state == IDLE);
    assign abort_act = abort && (state != IDLE);
    assign m_dec     = cur_m - WIDTH'(1);
    assign steps_inc = (&steps) ? steps : steps + STEP_W'(1);

    // Classify the current reduction and detect errors before the step commits.
    always_comb begin
        m_zero    = (cur_m == '0);
        n_zero    = (n == '0);
        step_push = !m_zero && !n_zero;
        step_pop  = m_zero && !stk_empty;
        err_stack = step_push && stk_full;
        err_n     = m_zero && (&n);
        err_limit = (MAX_STEPS != 0) && (steps == STEP_W'(MAX_STEPS));
        fail      = err_stack || err_n || err_limit;
        run_done  = fail || (m_zero && stk_empty);
        fail_code = ST_OK;
        if (err_stack)
            fail_code = ST_STACK_OVF;
        else if (err_n)
            fail_code = ST_N_OVF;
        else if (err_limit)
            fail_code = ST_STEP_LIMIT;
    end

    // Stack operations only happen on a committed RUN step; acceptance or abort empties it.
    always_comb begin
        stk_push  = (state == RUN) && !abort && !fail && step_push;
        stk_pop   = (state == RUN) && !abort && !fail && step_pop;
        stk_clear = start_acc || abort_act;
    end

    machine_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clear     (stk_clear),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (m_dec),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state: abort outranks completion and the result handshake.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_valid) state_nxt = RUN;
            RUN: begin
                if (abort)
                    state_nxt = IDLE;
                else if (run_done)
                    state_nxt = DONE;
            end
            DONE: if (abort || res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs decoded from state alone.
    always_comb begin
        start_ready = (state == IDLE);
        busy        = (state == RUN);
        res_valid   = (state == DONE);
    end

    // Datapath: operand capture, one reduction per RUN cycle; a failing step leaves n/steps untouched.
    always_ff @(posedge clk) begin
        if (rst || abort_act) begin
            cur_m  <= '0;
            n      <= '0;
            steps  <= '0;
            status <= ST_OK;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_valid) begin
                        cur_m  <= start_m;
                        n      <= start_n;
                        steps  <= '0;
                        status <= ST_OK;
                    end
                end
                RUN: begin
                    if (fail) begin
                        status <= fail_code;
                    end else begin
                        steps <= steps_inc;
                        if (m_zero) begin
                            n <= n + WIDTH'(1);
                            if (!stk_empty)
                                cur_m <= stk_top;
                        end else if (n_zero) begin
                            cur_m <= m_dec;
                            n     <= WIDTH'(1);
                        end else begin
                            n <= n - WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_value  = n;
    assign res_status = status;
    assign res_steps  = steps;

endmodule

// File: tb/tb_ackermann_machine.sv
// Self-checking bench: four differently parameterised machines share one stimulus stream
// and are compared against a rule-level reference model plus closed-form Ackermann values.
module tb_ackermann_machine;

    localparam int N = 4;

    // instance 0: defaults, 1: shallow stack, 2: 4-bit operands, 3: step budget 10
    int pw[N] = '{30, 30, 4, 30};
    int pd[N] = '{256, 4, 256, 256};
    int pm[N] = '{0, 0, 0, 10};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid = 1'b0;
    logic        abort = 1'b0;
    logic        res_ready = 1'b0;
    logic [29:0] start_m = '0;
    logic [29:0] start_n = '0;

    logic [N-1:0] sr, rv, bz;
    logic [29:0]  val [N];
    logic [1:0]   st  [N];
    logic [31:0]  sp  [N];
    logic [3:0]   val4;

    int n_chk = 0;
    int n_fail = 0;

    assign val[2] = {26'd0, val4};

    always #5 clk = ~clk;

    ackermann_machine #(.WIDTH(30), .STACK_DEPTH(256), .STEP_W(32), .MAX_STEPS(0)) u_main (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr[0]),
        .start_m(start_m), .start_n(start_n), .abort(abort), .res_valid(rv[0]),
        .res_ready(res_ready), .res_value(val[0]), .res_status(st[0]), .res_steps(sp[0]), .busy(bz[0]));

    ackermann_machine #(.WIDTH(30), .STACK_DEPTH(4), .STEP_W(32), .MAX_STEPS(0)) u_stk (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr[1]),
        .start_m(start_m), .start_n(start_n), .abort(abort), .res_valid(rv[1]),
        .res_ready(res_ready), .res_value(val[1]), .res_status(st[1]), .res_steps(sp[1]), .busy(bz[1]));

    ackermann_machine #(.WIDTH(4), .STACK_DEPTH(256), .STEP_W(32), .MAX_STEPS(0)) u_nw (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr[2]),
        .start_m(start_m[3:0]), .start_n(start_n[3:0]), .abort(abort), .res_valid(rv[2]),
        .res_ready(res_ready), .res_value(val4), .res_status(st[2]), .res_steps(sp[2]), .busy(bz[2]));

    ackermann_machine #(.WIDTH(30), .STACK_DEPTH(256), .STEP_W(32), .MAX_STEPS(10)) u_lim (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr[3]),
        .start_m(start_m), .start_n(start_n), .abort(abort), .res_valid(rv[3]),
        .res_ready(res_ready), .res_value(val[3]), .res_status(st[3]), .res_steps(sp[3]), .busy(bz[3]));

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: apply the reduction rules on a queue-as-stack, with the error checks
    // evaluated before each step in priority order.
    function automatic void model(input longint m0, input longint n0, input int w, input int d,
                                  input int ms, output longint v, output int s, output longint k);
        longint q[$];
        longint cm, nn, nmax;
        nmax = (longint'(1) << w) - 1;
        cm = m0 & nmax;
        nn = n0 & nmax;
        k = 0;
        s = 0;
        while (1) begin
            if (cm != 0 && nn != 0 && q.size() >= d) begin s = 1; break; end
            if (cm == 0 && nn == nmax) begin s = 2; break; end
            if (ms != 0 && k == ms) begin s = 3; break; end
            k++;
            if (cm == 0) begin
                nn++;
                if (q.size() == 0) break;
                cm = q.pop_back();
            end else if (nn == 0) begin
                cm--;
                nn = 1;
            end else begin
                q.push_back(cm - 1);
                nn--;
            end
        end
        v = nn;
    endfunction

    function automatic longint ack_closed(input int m, input longint n);
        case (m)
            0: return n + 1;
            1: return n + 2;
            2: return 2 * n + 3;
            default: return (longint'(1) << (n + 3)) - 3;
        endcase
    endfunction

    // One transaction on all instances, optional res_ready back-pressure, then handshake.
    task automatic run_one(input int m, input longint n, input int hold);
        int lat[N];
        bit all_done;
        longint v, k;
        int s;
        logic [29:0] hv;
        logic [1:0]  hs;
        logic [31:0] hk;
        bit stable;
        @(negedge clk);
        chk("start_ready_idle", sr, 4'hF);
        start_valid = 1'b1;
        start_m = 30'(m);
        start_n = 30'(n);
        @(posedge clk);
        #1 start_valid = 1'b0;
        foreach (lat[i]) lat[i] = 0;
        all_done = 1'b0;
        for (int c = 1; c <= 20000 && !all_done; c++) begin
            @(posedge clk);
            #1;
            all_done = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (rv[i] && lat[i] == 0) lat[i] = c;
                if (lat[i] == 0) all_done = 1'b0;
            end
        end
        if (!all_done) chk("timeout", 0, 1);
        for (int i = 0; i < N; i++) begin
            model(m, n, pw[i], pd[i], pm[i], v, s, k);
            chk($sformatf("value%0d m=%0d n=%0d", i, m, n), val[i], v);
            chk($sformatf("status%0d m=%0d n=%0d", i, m, n), st[i], s);
            chk($sformatf("steps%0d m=%0d n=%0d", i, m, n), sp[i], k);
            if (i == 0) begin
                // k steps on the k edges after acceptance; a failing check costs one more RUN cycle
                chk("latency0", lat[0], k + (s != 0 ? 1 : 0));
                if (s == 0) chk("closed_form0", val[0], ack_closed(m, n));
            end
        end
        if (hold > 0) begin
            hv = val[0]; hs = st[0]; hk = sp[0];
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                #1;
                if (val[0] !== hv || st[0] !== hs || sp[0] !== hk || rv[0] !== 1'b1 || sr[0] !== 1'b0)
                    stable = 1'b0;
            end
            chk("hold_stable", stable, 1);
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("res_valid_clr", rv, 0);
        chk("start_ready_back", sr, 4'hF);
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start_ready", sr, 4'hF);
        chk("rst_res_valid", rv, 0);
        chk("rst_busy", bz, 0);
        chk("rst_value0", val[0], 0);
        chk("rst_steps0", sp[0], 0);
        @(negedge clk);
        rst = 1'b0;

        run_one(0, 0, 0);
        run_one(1, 0, 0);
        run_one(1, 2, 0);
        run_one(2, 3, 5);
        run_one(3, 3, 20);
        run_one(0, (longint'(1) << 30) - 1, 0);

        for (int t = 0; t < 10; t++) begin
            int m;
            longint n;
            m = $urandom_range(0, 3);
            case (m)
                0: n = $urandom_range(0, 1000);
                1: n = $urandom_range(0, 20);
                2: n = $urandom_range(0, 10);
                default: n = $urandom_range(0, 3);
            endcase
            run_one(m, n, $urandom_range(0, 3));
        end

        // abort mid-RUN
        @(negedge clk);
        start_valid = 1'b1; start_m = 30'd2; start_n = 30'd3;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_res_valid", rv, 0);
        chk("abort_busy", bz, 0);
        chk("abort_start_ready", sr, 4'hF);
        chk("abort_value0", val[0], 0);
        @(negedge clk);
        abort = 1'b0;
        run_one(1, 2, 0);

        // reset mid-RUN
        @(negedge clk);
        start_valid = 1'b1; start_m = 30'd3; start_n = 30'd3;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("pre_rst_busy0", bz[0], 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_res_valid", rv, 0);
        chk("mid_rst_busy", bz, 0);
        chk("mid_rst_start_ready", sr, 4'hF);
        chk("mid_rst_value0", val[0], 0);
        chk("mid_rst_status0", st[0], 0);
        chk("mid_rst_steps0", sp[0], 0);
        @(negedge clk);
        rst = 1'b0;
        run_one(2, 2, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
